rng_bcd_gen: RTL and testbench

Parametrised random-digit generator. It is the successor to the fixed four-digit RNG project block. A free-running maximal-length LFSR supplies entropy. On a fetch request, the block assembles NUM_DIGITS uniformly distributed BCD digits by rejection sampling 4-bit nibbles, then presents them with a one-cycle valid strobe. It drives the seven-segment display path and any consumer needing decimal random values.

---
 rtl/rng_pkg.sv | 27 ++
 rtl/rng_lfsr_step.sv | 23 ++
 rtl/rng_bcd_gen.sv | 129 ++++++++++++
 tb/tb_rng_bcd_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared definitions for the BCD random-digit generator: FSM state type,
// LFSR tap masks for the supported widths, and the BCD acceptance limit.
package rng_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_GATHER = 1'b1
    } rng_state_t;

    localparam int unsigned BCD_MAX       = 9;
    localparam int unsigned STEPS_PER_CLK = 4;

    // Maximal-length Fibonacci tap masks; bit (t-1) set for tap t.
    // A zero return marks an unsupported width.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;  // 8,6,5,4
            16:      taps = 32'h0000_D008;  // 16,15,13,4
            24:      taps = 32'h00E1_0000;  // 24,23,22,17
            32:      taps = 32'h8020_0003;  // 32,22,2,1
            default: taps = '0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/rng_lfsr_step.sv
// Combinational next state of a Fibonacci LFSR advanced by STEPS_PER_CLK
// serial shifts. Shifts toward the MSB; feedback enters at bit 0.
module rng_lfsr_step
    import rng_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] lfsr_cur,
    output logic [WIDTH-1:0] lfsr_nxt
);

    localparam logic [31:0]      TAP_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS    = TAP_ALL[WIDTH-1:0];

    // Unrolled serial shifts: each step feeds the parity of the tapped bits back in.
    always_comb begin
        lfsr_nxt = lfsr_cur;
        for (int unsigned i = 0; i < STEPS_PER_CLK; i++) begin
            lfsr_nxt = {lfsr_nxt[WIDTH-2:0], ^(lfsr_nxt & TAPS)};
        end
    end

endmodule

// File: rtl/rng_bcd_gen.sv
// Random BCD digit generator: a free-running LFSR feeds rejection sampling
// of 4-bit nibbles into NUM_DIGITS decimal digits per fetch.
// Optional feature macro: RNG_SEED_LOAD_EN (adds seed_load / seed_value).
module rng_bcd_gen
    import rng_pkg::*;
#(
    parameter int unsigned           NUM_DIGITS = 4,
    parameter int unsigned           LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_request,
`ifdef RNG_SEED_LOAD_EN
    input  logic                    seed_load,
    input  logic [LFSR_WIDTH-1:0]   seed_value,
`endif
    output logic                    busy,
    output logic                    digits_valid,
    output logic [4*NUM_DIGITS-1:0] digits
);

    localparam int unsigned           DW        = 4 * NUM_DIGITS;
    localparam int unsigned           CW        = $clog2(NUM_DIGITS + 1);
    localparam logic [LFSR_WIDTH-1:0] LFSR_ONE  = LFSR_WIDTH'(1);
    localparam logic [LFSR_WIDTH-1:0] RESET_VAL = (SEED == '0) ? LFSR_ONE : SEED;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("rng_bcd_gen: NUM_DIGITS must be 1..8");
    end
    if (lfsr_taps(LFSR_WIDTH) == '0) begin : g_bad_lfsr_width
        $error("rng_bcd_gen: LFSR_WIDTH must be 8, 16, 24 or 32");
    end

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_step;
    logic                  seed_ld;
    logic [LFSR_WIDTH-1:0] seed_val;

    rng_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         digits_q, digits_d;
    logic                  valid_q, valid_d;
    logic [3:0]            nib;

`ifdef RNG_SEED_LOAD_EN
    assign seed_ld  = seed_load;
    assign seed_val = (seed_value == '0) ? LFSR_ONE : seed_value;
`else
    assign seed_ld  = 1'b0;
    assign seed_val = RESET_VAL;
`endif

    rng_lfsr_step #(
        .WIDTH (LFSR_WIDTH)
    ) u_step (
        .lfsr_cur (lfsr_q),
        .lfsr_nxt (lfsr_step)
    );

    // LFSR register: reset or seed load override the free-running step.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= RESET_VAL;
        end else if (seed_ld) begin
            lfsr_q <= seed_val;
        end else begin
            lfsr_q <= lfsr_step;
        end
    end

    assign nib = lfsr_q[3:0];

    // Next-state logic: accept nibbles <= 9 into the shadow until NUM_DIGITS are held.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        digits_d = digits_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_request && !seed_ld) begin
                    state_d  = ST_GATHER;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            ST_GATHER: begin
                if (seed_ld) begin
                    state_d = ST_IDLE;
                end else if (nib <= 4'(BCD_MAX)) begin
                    // Truncating the concatenation shifts left; also valid for one digit.
                    shadow_d = DW'({shadow_q, nib});
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(NUM_DIGITS - 1)) begin
                        digits_d = shadow_d;
                        valid_d  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, counter, shadow and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
        end
    end

    assign busy         = (state_q == ST_GATHER);
    assign digits_valid = valid_q;
    assign digits       = digits_q;

endmodule

// File: tb/tb_rng_bcd_gen.sv
// Self-checking bench for rng_bcd_gen: directed fetch/abort scenarios on a
// 4-digit/16-bit instance against a decimal-level reference model, plus
// statistical sweeps on 1-digit/8-bit and 8-digit/32-bit instances.
// Seed-load scenarios build when RNG_SEED_LOAD_EN is defined.
module tb_rng_bcd_gen;

    logic        clk;
    logic        rst;
    logic        fetch_request;
    logic        busy;
    logic        digits_valid;
    logic [15:0] digits;
`ifdef RNG_SEED_LOAD_EN
    logic        seed_load;
    logic [15:0] seed_value;
`endif

    logic        f_s1, v_s1, b_s1;
    logic [3:0]  d_s1;
    logic        f_s8, v_s8, b_s8;
    logic [31:0] d_s8;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [15:0] m_lfsr;

    rng_bcd_gen #(
        .NUM_DIGITS (4),
        .LFSR_WIDTH (16),
        .SEED       (16'h0001)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_request (fetch_request),
`ifdef RNG_SEED_LOAD_EN
        .seed_load     (seed_load),
        .seed_value    (seed_value),
`endif
        .busy          (busy),
        .digits_valid  (digits_valid),
        .digits        (digits)
    );

    rng_bcd_gen #(
        .NUM_DIGITS (1),
        .LFSR_WIDTH (8),
        .SEED       (8'h5A)
    ) u_s1 (
        .clk           (clk),
        .rst           (rst),
        .fetch_request (f_s1),
`ifdef RNG_SEED_LOAD_EN
        .seed_load     (1'b0),
        .seed_value    (8'h00),
`endif
        .busy          (b_s1),
        .digits_valid  (v_s1),
        .digits        (d_s1)
    );

    rng_bcd_gen #(
        .NUM_DIGITS (8),
        .LFSR_WIDTH (32),
        .SEED       (32'h1234_5678)
    ) u_s8 (
        .clk           (clk),
        .rst           (rst),
        .fetch_request (f_s8),
`ifdef RNG_SEED_LOAD_EN
        .seed_load     (1'b0),
        .seed_value    (32'h0),
`endif
        .busy          (b_s8),
        .digits_valid  (v_s8),
        .digits        (d_s8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Polynomial x^16+x^15+x^13+x^4+1, four serial shifts per clock.
    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) r = {r[14:0], r[15] ^ r[14] ^ r[12] ^ r[3]};
        return r;
    endfunction

    // Reference LFSR kept in lockstep with the DUT's clock/reset/seed inputs.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'h0001;
`ifdef RNG_SEED_LOAD_EN
        else if (seed_load) m_lfsr <= (seed_value == 16'h0) ? 16'h0001 : seed_value;
`endif
        else m_lfsr <= m_step(m_lfsr);
    end

    // Count valid strobes of the main instance.
    always @(negedge clk) if (digits_valid === 1'b1) pulses++;

    // Expected result from state s: decimal value built digit by digit, then BCD-packed.
    task automatic predict(input logic [15:0] s_in, output logic [15:0] bcd, output int lat);
        logic [15:0] s;
        int unsigned val;
        int          got;
        s = s_in; val = 0; got = 0; lat = 0;
        while (got < 4) begin
            lat++;
            if (s[3:0] <= 4'd9) begin
                val = val * 10 + 32'(s[3:0]);
                got++;
            end
            s = m_step(s);
        end
        for (int i = 0; i < 4; i++) begin
            bcd[4*i +: 4] = 4'(val % 10);
            val = val / 10;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic main_fetch(input bit extra, output logic [15:0] got_d);
        logic [15:0] exp_d;
        int          exp_lat;
        int          lat;
        int          p0;
        bit          got;
        @(negedge clk);
        fetch_request = 1'b1;
        @(posedge clk); #1;
        predict(m_lfsr, exp_d, exp_lat);
        p0  = pulses;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            if (lat == 0) chk("busy_rise", 64'(busy), 64'd1);
            fetch_request = extra && (lat == 1);
            @(posedge clk); #1;
            lat++;
            got = digits_valid;
        end
        fetch_request = 1'b0;
        chk("valid_timeout", 64'(got), 64'd1);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy_fall", 64'(busy), 64'd0);
        chk("digits", 64'(digits), 64'(exp_d));
        for (int k = 0; k < 4; k++) chk("nib_le9", 64'(digits[4*k +: 4] <= 4'd9), 64'd1);
        got_d = digits;
        @(posedge clk); #1;
        chk("valid_width", 64'(digits_valid), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("one_pulse", 64'(pulses - p0), 64'd1);
        chk("idle_after", 64'(busy), 64'd0);
        chk("digits_hold", 64'(digits), 64'(exp_d));
        chk("lfsr_track", 64'(dut.lfsr_q), 64'(m_lfsr));
    endtask

    task automatic sweep(input int which);
        int unsigned hist [10];
        int          nd;
        int          lat;
        int          gap;
        bit          got;
        logic [31:0] d;
        logic [3:0]  nib;
        nd = (which == 0) ? 1 : 8;
        for (int v = 0; v < 10; v++) hist[v] = 0;
        for (int n = 0; n < 1000; n++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            @(negedge clk);
            if (which == 0) f_s1 = 1'b1; else f_s8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            f_s1 = 1'b0; f_s8 = 1'b0;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 300) begin
                @(posedge clk); #1;
                lat++;
                got = (which == 0) ? v_s1 : v_s8;
            end
            chk("sw_timeout", 64'(got), 64'd1);
            chk("sw_lat_min", 64'(lat >= nd), 64'd1);
            d = (which == 0) ? {28'h0, d_s1} : d_s8;
            for (int k = 0; k < nd; k++) begin
                nib = d[4*k +: 4];
                chk("sw_nib_le9", 64'(nib <= 4'd9), 64'd1);
                if (nib <= 4'd9) hist[nib]++;
            end
        end
        for (int v = 0; v < 10; v++) begin
            chk("sw_hist_lo", 64'(hist[v] * 100 >= 7 * 1000 * nd), 64'd1);
            chk("sw_hist_hi", 64'(hist[v] * 100 <= 13 * 1000 * nd), 64'd1);
        end
    endtask

    initial begin
        logic [15:0] d_a;
        logic [15:0] d_b;
        logic [15:0] prev;
        int          p0;

        rst = 1'b1; fetch_request = 1'b0; f_s1 = 1'b0; f_s8 = 1'b0;
`ifdef RNG_SEED_LOAD_EN
        seed_load = 1'b0; seed_value = 16'h0;
`endif
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", 64'(digits), 64'd0);
        chk("rst_valid", 64'(digits_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_lfsr_seed", 64'(dut.lfsr_q), 64'h0001);

        // Single fetch, then a fetch with an ignored second pulse mid-gather
        main_fetch(1'b0, d_a);
        main_fetch(1'b1, d_a);

`ifdef RNG_SEED_LOAD_EN
        // Reproducibility from a loaded seed
        @(negedge clk); seed_load = 1'b1; seed_value = 16'hACE1;
        @(posedge clk); #1; seed_load = 1'b0;
        main_fetch(1'b0, d_a);
        @(negedge clk); seed_load = 1'b1; seed_value = 16'hACE1;
        @(posedge clk); #1; seed_load = 1'b0;
        main_fetch(1'b0, d_b);
        chk("seed_repro", 64'(d_b), 64'(d_a));

        // Zero seed substitutes 1
        @(negedge clk); seed_load = 1'b1; seed_value = 16'h0000;
        @(posedge clk); #1;
        chk("seed_zero", 64'(dut.lfsr_q), 64'h0001);
        @(negedge clk); seed_load = 1'b0;

        // Seed load mid-gather aborts and keeps digits
        prev = digits;
        @(negedge clk); fetch_request = 1'b1;
        @(posedge clk);
        @(negedge clk); fetch_request = 1'b0;
        p0 = pulses;
        @(negedge clk); seed_load = 1'b1; seed_value = 16'hBEEF;
        chk("sl_busy_before", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("sl_abort_busy", 64'(busy), 64'd0);
        chk("sl_abort_lfsr", 64'(dut.lfsr_q), 64'hBEEF);
        @(negedge clk); seed_load = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("sl_abort_digits", 64'(digits), 64'(prev));
        chk("sl_abort_nopulse", 64'(pulses - p0), 64'd0);
        chk("sl_abort_idle", 64'(busy), 64'd0);
`endif

        // Reset two cycles into a gather
        @(negedge clk); fetch_request = 1'b1;
        @(posedge clk);
        @(negedge clk); fetch_request = 1'b0;
        p0 = pulses;
        @(posedge clk);
        @(negedge clk);
        chk("ra_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ra_busy", 64'(busy), 64'd0);
        chk("ra_digits", 64'(digits), 64'd0);
        chk("ra_lfsr", 64'(dut.lfsr_q), 64'h0001);
        @(negedge clk); rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("ra_nopulse", 64'(pulses - p0), 64'd0);
        chk("ra_lfsr_track", 64'(dut.lfsr_q), 64'(m_lfsr));

        // Normal operation after the abort
        main_fetch(1'b0, d_a);

        // Parameter sweeps
        sweep(0);
        sweep(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
